// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4-input registered mux.
// Produces a one-hot grant with mux select, and an owner tag aligned with the mux output register.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [0:3] req,
    output logic [0:3] gnt,
    output logic [0:1] select,
    output logic       busy,
    output logic       out_valid,
    output logic [0:1] out_owner
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [0:3]    gnt_q, gnt_d;
    logic [1:0]    sel_q, sel_d;
    logic          busy_q, busy_d;
    logic          out_valid_q;
    logic [1:0]    out_owner_q;

    logic [1:0]    next_ptr_s;
    logic [0:3]    others_s;
    logic [2:0]    pick_s;
    logic          do_grant_s;
    logic          do_idle_s;

    function automatic logic [0:3] onehot(input logic [1:0] idx);
        logic [0:3] v;
        v      = 4'b0000;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Returns {found, index}: scan start, start+1, ... (mod 4); lowest offset wins.
    function automatic logic [2:0] rr_pick(input logic [0:3] r, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = start;
        found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            idx   = start + 2'(i);
            win   = r[idx] ? idx : win;
            found = found | r[idx];
        end
        return {found, win};
    endfunction

    // Next-state decision: initial grant, release hand-off, forced rotation, hold counting
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        next_ptr_s = sel_q + 2'd1;
        others_s   = req & ~onehot(sel_q);
        pick_s     = 3'b000;
        do_grant_s = 1'b0;
        do_idle_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pick_s     = rr_pick(req, ptr_q);
                do_grant_s = pick_s[2];
                do_idle_s  = ~pick_s[2];
            end
            ST_GRANT: begin
                if (!req[sel_q]) begin
                    ptr_d      = next_ptr_s;
                    pick_s     = rr_pick(req, next_ptr_s);
                    do_grant_s = pick_s[2];
                    do_idle_s  = ~pick_s[2];
                end else if (|others_s) begin
                    if (hold_q == HOLD_LAST) begin
                        ptr_d      = next_ptr_s;
                        pick_s     = rr_pick(others_s, next_ptr_s);
                        do_grant_s = 1'b1;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end else begin
                    // Uncontested owner: saturate so a late contender rotates on the next edge
                    if (hold_q == HOLD_LAST) begin
                        hold_d = hold_q;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            default: begin
                do_idle_s = 1'b1;
            end
        endcase

        if (do_grant_s) begin
            state_d = ST_GRANT;
            gnt_d   = onehot(pick_s[1:0]);
            sel_d   = pick_s[1:0];
            busy_d  = 1'b1;
            hold_d  = {HW{1'b0}};
        end else if (do_idle_s) begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
            hold_d  = {HW{1'b0}};
        end else begin
            state_d = state_d;
        end
    end

    // Arbitration state and grant registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            hold_q  <= {HW{1'b0}};
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    // Owner tag delayed one edge to line up with the mux output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_owner_q <= 2'd0;
        end else begin
            out_valid_q <= busy_q;
            out_owner_q <= sel_q;
        end
    end

    assign gnt       = gnt_q;
    assign select    = sel_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_owner = out_owner_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed request sequences, a cycle-level reference model
// compared on every edge, and literal expectations at key points.
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       rst_n;
    logic [0:3] req;
    logic [0:3] gnt;
    logic [0:1] select;
    logic       busy;
    logic       out_valid;
    logic [0:1] out_owner;

    int checks   = 0;
    int failures = 0;

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .select    (select),
        .busy      (busy),
        .out_valid (out_valid),
        .out_owner (out_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: owner as an integer, streak = cycles the owner has held so far
    int m_owner, m_ptr, m_streak, m_sel, m_busy, m_ov, m_oo;

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_streak = 0;
        m_sel = 0; m_busy = 0; m_ov = 0; m_oo = 0;
    endtask

    function automatic int first_from(input logic [0:3] r, input int start);
        for (int i = 0; i < 4; i++) begin
            if (r[(start + i) % 4]) return (start + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [0:3] r);
        int w;
        logic [0:3] rm;
        w = -1;
        m_ov = m_busy;
        m_oo = m_sel;
        if (m_owner < 0) begin
            w = first_from(r, m_ptr);
        end else if (!r[m_owner]) begin
            m_ptr = (m_owner + 1) % 4;
            w = first_from(r, m_ptr);
            if (w < 0) begin m_owner = -1; m_busy = 0; end
        end else begin
            rm = r;
            rm[m_owner] = 1'b0;
            if (rm != 4'b0000 && m_streak >= MAX_HOLD) begin
                m_ptr = (m_owner + 1) % 4;
                w = first_from(rm, m_ptr);
            end else if (m_streak < MAX_HOLD) begin
                m_streak++;
            end
        end
        if (w >= 0) begin
            m_owner = w; m_sel = w; m_busy = 1; m_streak = 1;
        end
    endtask

    // Model update and compare just after every active edge
    initial begin
        logic [0:3] exp_g;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                model_step(req);
                #1;
                exp_g = (m_owner >= 0) ? (4'b1000 >> m_owner) : 4'b0000;
                chk("model_gnt", 8'(gnt), 8'(exp_g));
                chk("model_select", 8'(select), 8'(m_sel));
                chk("model_busy", 8'(busy), 8'(m_busy));
                chk("model_out_valid", 8'(out_valid), 8'(m_ov));
                chk("model_out_owner", 8'(out_owner), 8'(m_oo));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        // Test 1: outputs held at zero during reset despite requests
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", 8'(gnt), 8'h0);
            chk("rst_busy", 8'(busy), 8'h0);
            chk("rst_select", 8'(select), 8'h0);
            chk("rst_out_valid", 8'(out_valid), 8'h0);
            chk("rst_out_owner", 8'(out_owner), 8'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_gnt_A", 8'(gnt), 8'(4'b1000));
        chk("t1_select", 8'(select), 8'h0);
        @(negedge clk);
        chk("t1_out_valid", 8'(out_valid), 8'h1);
        chk("t1_out_owner", 8'(out_owner), 8'h0);

        // Test 3: full contention rotates every MAX_HOLD cycles
        repeat (6) @(negedge clk);
        chk("t3_A_last", 8'(gnt), 8'(4'b1000));
        @(negedge clk);
        chk("t3_B_first", 8'(gnt), 8'(4'b0100));
        repeat (23) @(negedge clk);
        chk("t3_D_last", 8'(gnt), 8'(4'b0001));
        @(negedge clk);
        chk("t3_A_again", 8'(gnt), 8'(4'b1000));
        repeat (8) @(negedge clk);

        // Test 2: lone requester C is never rotated away
        reset_pulse();
        req = 4'b0010;
        @(negedge clk);
        chk("t2_gnt_C", 8'(gnt), 8'(4'b0010));
        chk("t2_select", 8'(select), 8'h2);
        repeat (19) @(negedge clk);
        chk("t2_still_C", 8'(gnt), 8'(4'b0010));
        chk("t2_busy", 8'(busy), 8'h1);
        req = 4'b0000;
        @(negedge clk);
        chk("t2_idle_gnt", 8'(gnt), 8'h0);
        chk("t2_idle_busy", 8'(busy), 8'h0);
        chk("t2_select_held", 8'(select), 8'h2);
        @(negedge clk);
        chk("t2_out_valid", 8'(out_valid), 8'h0);

        // Test 4: release hands off without an idle cycle
        reset_pulse();
        req = 4'b1101;
        @(negedge clk);
        chk("t4_gnt_A", 8'(gnt), 8'(4'b1000));
        req = 4'b0101;
        @(negedge clk);
        chk("t4_gnt_B", 8'(gnt), 8'(4'b0100));
        chk("t4_busy", 8'(busy), 8'h1);
        req = 4'b0001;
        @(negedge clk);
        chk("t4_gnt_D", 8'(gnt), 8'(4'b0001));
        chk("t4_select_D", 8'(select), 8'h3);

        // Test 5: D releasing wraps the pointer to A ahead of C
        req = 4'b1011;
        @(negedge clk);
        chk("t5_hold_D", 8'(gnt), 8'(4'b0001));
        req = 4'b1010;
        @(negedge clk);
        chk("t5_wrap_A", 8'(gnt), 8'(4'b1000));

        // Test 6: asynchronous reset mid-grant
        reset_pulse();
        req = 4'b0010;
        @(negedge clk);
        req = 4'b1111;
        repeat (3) @(negedge clk);
        chk("t6_C_held", 8'(gnt), 8'(4'b0010));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_gnt", 8'(gnt), 8'h0);
        chk("t6_async_busy", 8'(busy), 8'h0);
        chk("t6_async_out_valid", 8'(out_valid), 8'h0);
        #1;
        rst_n = 1'b1;
        req   = 4'b0101;
        @(negedge clk);
        chk("t6_first_B", 8'(gnt), 8'(4'b0100));

        // Saturated lone owner: a late contender takes over on the next edge
        reset_pulse();
        req = 4'b0100;
        repeat (12) @(negedge clk);
        chk("t7_B_alone", 8'(gnt), 8'(4'b0100));
        req = 4'b0110;
        @(negedge clk);
        chk("t7_rotate_C", 8'(gnt), 8'(4'b0010));
        chk("t7_out_owner_B", 8'(out_owner), 8'h1);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares the 4-input, 16-bit registered mux among four requesters (A..D).
It decides each cycle which requester owns the mux and drives the mux select and a one-hot grant.
It also produces a valid/owner pair aligned with the mux's one-cycle registered output.
A hold limit stops one requester from starving the others.

Parameters:
MAX_HOLD, 8, maximum consecutive grant cycles for one owner while another requester is waiting (legal range 1..256)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
req  input  [0:3]  request lines; req[0]=A, req[1]=B, req[2]=C, req[3]=D; level, held while the requester wants the mux
gnt  output  [0:3]  one-hot grant, same bit order as req; all-zero when idle
select  output  [0:1]  mux select: 00=A, 01=B, 10=C, 11=D
busy  output  1  high while any grant is active (gnt != 0)
out_valid  output  1  mux output holds data from a granted source (busy delayed one cycle)
out_owner  output  [0:1]  index of the source whose data is on the mux output (select delayed one cycle)

Behaviour:
- Reset (rst_n low, asynchronous): gnt=0000, select=00, busy=0, out_valid=0, out_owner=00.
  - Internal state on reset: state=IDLE, priority pointer ptr=0 (A), hold_cnt=0.
  - Reset asserted mid-grant clears everything immediately, without waiting for a clock edge.
- All outputs are registered; nothing is combinational from req.
- Requester search: scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first asserted req wins.
- IDLE:
  - With no req: remain in IDLE. gnt=0 and busy=0. select holds its last value so the mux input stays stable.
  - With any req: at the next edge, grant the winner of the search. gnt=onehot(winner), select=winner, busy=1, hold_cnt=0, state goes to GRANT.
  - Latency from req to gnt is 1 edge.
- GRANT, owner k, evaluated each edge:
  - Release (req[k]=0): ptr=(k+1) mod 4.
    - If any req is set, grant the search winner using the new ptr in that same edge. No idle bubble; hold_cnt=0.
    - Otherwise go to IDLE with gnt=0000 and busy=0.
  - Forced rotation: req[k]=1, hold_cnt=MAX_HOLD-1, and any other req set.
    - ptr=(k+1) mod 4; grant the search winner excluding k; hold_cnt=0.
  - Uncontested hold: req[k]=1 and no other req. Stay on k; hold_cnt saturates at MAX_HOLD-1.
    - If a contender then appears while hold_cnt is saturated, rotate at the next edge.
  - Contested hold below limit: stay on k; hold_cnt+1.
- Invariants:
  - gnt is always one-hot or zero.
  - select always equals the index of the set gnt bit whenever busy=1.
  - select changes only on the same edge as gnt.
- MAX_HOLD=1: under contention, rotation happens every cycle.
- ptr wrap: owner D releasing gives ptr=0, so A has top priority next.
- Output alignment: at each edge, out_valid<=busy and out_owner<=select. This matches the mux's one-edge register latency.
- hold_cnt width is ceil(log2(MAX_HOLD)), minimum 1 bit.

Test Plan:
1. Reset with rst_n low for 3 cycles and req=1111 -> all outputs 0 throughout. Release rst_n with req=1111 -> next edge gnt=1000, select=00; one edge later out_valid=1, out_owner=00.
2. req=0010 only, held 20 cycles -> after 1 edge gnt=0010, select=10. No rotation for 20 cycles and busy stays 1. Drop req -> next edge gnt=0000, busy=0, select remains 10; one edge later out_valid=0.
3. MAX_HOLD=8, req=1111 held 40 cycles -> gnt runs A for 8 cycles, B 8, C 8, D 8, then A again. out_owner follows select exactly one cycle later.
4. A granted, req=1101, then A drops to req=0101 -> next edge gnt=0100 (B), no idle cycle. B drops to req=0001 -> next edge gnt=0001 (D), select=11.
5. D granted, req=1011, then D drops to req=1010 -> ptr wraps and the next edge grants A (gnt=1000), not C.
6. C granted with hold_cnt=3 and req=1111; pulse rst_n low mid-cycle -> gnt, busy and out_valid go 0 immediately, without a clock edge. After release with req=0101 -> first grant is B (ptr back to A, A not requesting).
